// File: rtl/calc_pkg.sv
// Shared operation/state types and the key-event priority encoder for the
// sequential four-function calculator.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLR,
        OP_EQ,
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX
    } state_t;

    // Clear > Equals > Add > Sub > Mul > Div; lower-priority events are dropped.
    function automatic op_t prio_op(input logic clr, input logic eq, input logic add,
                                    input logic sub, input logic mul, input logic div);
        op_t op;
        if (clr)      op = OP_CLR;
        else if (eq)  op = OP_EQ;
        else if (add) op = OP_ADD;
        else if (sub) op = OP_SUB;
        else if (mul) op = OP_MUL;
        else if (div) op = OP_DIV;
        else          op = OP_NONE;
        return op;
    endfunction

endpackage

// File: rtl/seq_four_func_calc_if.sv
// Key inputs, operand and result/status bus of the calculator core.
interface seq_four_func_calc_if #(parameter int W = 11);

    logic         Clear;
    logic         Equals;
    logic         Add;
    logic         Sub;
    logic         Mul;
    logic         Div;
    logic [W-1:0] Number;
    logic [W-1:0] Total;
    logic         Overflow;
    logic         DivZero;
    logic         Busy;
    logic         Done;

    modport master (
        output Clear, Equals, Add, Sub, Mul, Div, Number,
        input  Total, Overflow, DivZero, Busy, Done
    );

    modport slave (
        input  Clear, Equals, Add, Sub, Mul, Div, Number,
        output Total, Overflow, DivZero, Busy, Done
    );

endinterface

// File: rtl/seq_muldiv_unit.sv
// Magnitude shift-add multiplier and restoring divider, one bit per cycle,
// W iterations per operation.
module seq_muldiv_unit #(
    parameter int W = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mode_mul,
    input  logic [W-1:0]   a_mag,
    input  logic [W-1:0]   b_mag,
    input  logic           abort,
    output logic [2*W-1:0] result,
    output logic           last,
    output logic           ready
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(W);

    logic           run_q, run_d;
    logic           mul_q, mul_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    // acc: product accumulator (mul) or partial remainder (div)
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    // shr: multiplier shifting out (mul) or dividend shifting out / quotient in (div)
    logic [W-1:0]   shr_q, shr_d;
    logic [W:0]     rem_sh;
    logic [W+1:0]   trial;

    always_comb begin
        run_d   = run_q;
        mul_d   = mul_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        shr_d   = shr_q;
        rem_sh  = {acc_q[W-1:0], shr_q[W-1]};
        trial   = {1'b0, rem_sh} - {2'b00, mcand_q[W-1:0]};
        if (abort) begin
            run_d = 1'b0;
        end else if (start) begin
            run_d   = 1'b1;
            mul_d   = mode_mul;
            cnt_d   = '0;
            acc_d   = '0;
            mcand_d = {{W{1'b0}}, (mode_mul ? a_mag : b_mag)};
            shr_d   = mode_mul ? b_mag : a_mag;
        end else if (run_q && (cnt_q != CNT_DONE)) begin
            cnt_d = cnt_q + CW'(1);
            if (mul_q) begin
                if (shr_q[0]) acc_d = acc_q + mcand_q;
                mcand_d = mcand_q << 1;
                shr_d   = shr_q >> 1;
            end else if (trial[W+1]) begin
                acc_d = {{(W-1){1'b0}}, rem_sh};
                shr_d = {shr_q[W-2:0], 1'b0};
            end else begin
                acc_d = {{(W-1){1'b0}}, trial[W:0]};
                shr_d = {shr_q[W-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            mul_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            mul_q <= mul_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q   <= acc_d;
        mcand_q <= mcand_d;
        shr_q   <= shr_d;
    end

    assign result = mul_q ? acc_q : {{W{1'b0}}, shr_q};
    assign last   = run_q && (cnt_q == CNT_LAST);
    assign ready  = run_q && (cnt_q == CNT_DONE);

endmodule

// File: rtl/seq_four_func_calc.sv
// Accumulator-style four-function calculator: key edge detect, add/sub,
// sticky flags, sign handling and the IDLE/ITER/FIX sequencer around seq_muldiv_unit.
module seq_four_func_calc
    import calc_pkg::*;
#(
    parameter int W      = 11,
    parameter bit SIGNED = 1'b1
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    seq_four_func_calc_if.slave  bus
);

    logic [5:0]     key_d, key_q, key_evt;
    op_t            op;
    state_t         state_q, state_d;
    logic [W-1:0]   total_q, total_d;
    logic           ovf_q, ovf_d;
    logic           dz_q, dz_d;
    logic           done_q, done_d;
    logic           neg_q, neg_d;
    logic           is_mul_q, is_mul_d;

    logic           sign_a, sign_b;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     add_full, sub_full;
    logic           add_ovf, sub_ovf;
    logic           ud_start, ud_abort, ud_last, ud_ready;
    logic [2*W-1:0] ud_result, prod_s;
    logic [W:0]     prod_hi;
    logic [W-1:0]   quo, quo_s;
    logic           mul_ovf, div_ovf;

    assign key_d   = {bus.Clear, bus.Equals, bus.Add, bus.Sub, bus.Mul, bus.Div};
    assign key_evt = key_d & ~key_q;
    assign op      = prio_op(key_evt[5], key_evt[4], key_evt[3],
                             key_evt[2], key_evt[1], key_evt[0]);

    assign sign_a = SIGNED && total_q[W-1];
    assign sign_b = SIGNED && bus.Number[W-1];
    assign mag_a  = sign_a ? -total_q : total_q;
    assign mag_b  = sign_b ? -bus.Number : bus.Number;

    assign add_full = {1'b0, total_q} + {1'b0, bus.Number};
    assign sub_full = {1'b0, total_q} - {1'b0, bus.Number};
    assign add_ovf  = SIGNED ? ((total_q[W-1] == bus.Number[W-1]) && (add_full[W-1] != total_q[W-1]))
                             : add_full[W];
    assign sub_ovf  = SIGNED ? ((total_q[W-1] != bus.Number[W-1]) && (sub_full[W-1] != total_q[W-1]))
                             : sub_full[W];

    // Signed product fits in W bits only if bits [2W-1:W-1] are all equal.
    assign prod_s  = neg_q ? -ud_result : ud_result;
    assign prod_hi = prod_s[2*W-1:W-1];
    assign mul_ovf = SIGNED ? ((|prod_hi) && !(&prod_hi)) : (|ud_result[2*W-1:W]);
    assign quo     = ud_result[W-1:0];
    assign quo_s   = neg_q ? -quo : quo;
    assign div_ovf = SIGNED && !neg_q && quo[W-1];

    seq_muldiv_unit #(.W(W)) u_muldiv (
        .clk      (Clock),
        .rst_n    (Resetn),
        .start    (ud_start),
        .mode_mul (op == OP_MUL),
        .a_mag    (mag_a),
        .b_mag    (mag_b),
        .abort    (ud_abort),
        .result   (ud_result),
        .last     (ud_last),
        .ready    (ud_ready)
    );

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        neg_d    = neg_q;
        is_mul_d = is_mul_q;
        ud_start = 1'b0;
        ud_abort = 1'b0;
        if (op == OP_CLR) begin
            // An aborted Mul/Div produces no Done; a plain Clear does.
            total_d  = '0;
            ovf_d    = 1'b0;
            dz_d     = 1'b0;
            done_d   = (state_q == S_IDLE);
            ud_abort = (state_q != S_IDLE);
            state_d  = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    case (op)
                        OP_EQ: begin
                            total_d = bus.Number;
                            ovf_d   = 1'b0;
                            dz_d    = 1'b0;
                            done_d  = 1'b1;
                        end
                        OP_ADD: begin
                            total_d = add_full[W-1:0];
                            ovf_d   = ovf_q | add_ovf;
                            done_d  = 1'b1;
                        end
                        OP_SUB: begin
                            total_d = sub_full[W-1:0];
                            ovf_d   = ovf_q | sub_ovf;
                            done_d  = 1'b1;
                        end
                        OP_MUL, OP_DIV: begin
                            if ((op == OP_DIV) && (bus.Number == '0)) begin
                                dz_d   = 1'b1;
                                ovf_d  = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                ud_start = 1'b1;
                                is_mul_d = (op == OP_MUL);
                                neg_d    = sign_a ^ sign_b;
                                state_d  = S_ITER;
                            end
                        end
                        default: ;
                    endcase
                end
                S_ITER: begin
                    if (ud_last) state_d = S_FIX;
                end
                S_FIX: begin
                    if (ud_ready) begin
                        total_d = is_mul_q ? prod_s[W-1:0] : quo_s;
                        ovf_d   = ovf_q | (is_mul_q ? mul_ovf : div_ovf);
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            key_q    <= '0;
            state_q  <= S_IDLE;
            total_q  <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            neg_q    <= 1'b0;
            is_mul_q <= 1'b0;
        end else begin
            key_q    <= key_d;
            state_q  <= state_d;
            total_q  <= total_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
            neg_q    <= neg_d;
            is_mul_q <= is_mul_d;
        end
    end

    assign bus.Total    = total_q;
    assign bus.Overflow = ovf_q;
    assign bus.DivZero  = dz_q;
    assign bus.Busy     = (state_q != S_IDLE);
    assign bus.Done     = done_q;

endmodule

// File: tb/tb_seq_four_func_calc.sv
// Directed bench for seq_four_func_calc: a signed and an unsigned instance checked
// every cycle against an arithmetic model, plus hand-computed literal checks.
module tb_seq_four_func_calc;

    localparam int W = 11;
    localparam int K_CLR = 5, K_EQ = 4, K_ADD = 3, K_SUB = 2, K_MUL = 1, K_DIV = 0;

    logic Clock = 1'b0;
    logic Resetn;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 Clock = ~Clock;

    seq_four_func_calc_if #(.W(W)) if0 ();
    seq_four_func_calc_if #(.W(W)) if1 ();

    seq_four_func_calc #(.W(W), .SIGNED(1'b1)) dut0 (.Clock(Clock), .Resetn(Resetn), .bus(if0));
    seq_four_func_calc #(.W(W), .SIGNED(1'b0)) dut1 (.Clock(Clock), .Resetn(Resetn), .bus(if1));

    // ---------------- model state (index 0: signed, 1: unsigned) ----------------
    logic [W-1:0] m_total [2];
    logic [W-1:0] p_total [2];
    logic [5:0]   m_prev  [2];
    bit           m_ovf   [2];
    bit           p_ovf   [2];
    bit           m_dz    [2];
    bit           m_done  [2];
    int           m_busy  [2];

    task automatic cmp(string nm, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint sval(int u, logic [W-1:0] x);
        if (u == 0) return longint'($signed(x));
        return longint'(x);
    endfunction

    function automatic bit fits(int u, longint r);
        longint lim;
        lim = longint'(1) << (W - 1);
        if (u == 0) return (r >= -lim) && (r < lim);
        return (r >= 0) && (r < 2 * lim);
    endfunction

    function automatic logic [5:0] keys_of(int u);
        if (u == 0) return {if0.Clear, if0.Equals, if0.Add, if0.Sub, if0.Mul, if0.Div};
        return {if1.Clear, if1.Equals, if1.Add, if1.Sub, if1.Mul, if1.Div};
    endfunction

    function automatic logic [W-1:0] num_of(int u);
        return (u == 0) ? if0.Number : if1.Number;
    endfunction

    // {Total, Overflow, DivZero, Busy, Done}
    function automatic logic [W+3:0] outs_of(int u);
        if (u == 0) return {if0.Total, if0.Overflow, if0.DivZero, if0.Busy, if0.Done};
        return {if1.Total, if1.Overflow, if1.DivZero, if1.Busy, if1.Done};
    endfunction

    task automatic model_step(int u);
        logic [5:0]   k, e;
        logic [W-1:0] n;
        longint       a, b, r;
        bit           nd;
        k = keys_of(u);
        n = num_of(u);
        e = k & ~m_prev[u];
        m_prev[u] = k;
        nd = 1'b0;
        a = sval(u, m_total[u]);
        b = sval(u, n);
        if (e[K_CLR]) begin
            nd = (m_busy[u] == 0);
            m_busy[u] = 0;
            m_total[u] = '0;
            m_ovf[u] = 1'b0;
            m_dz[u] = 1'b0;
        end else if (m_busy[u] > 0) begin
            m_busy[u]--;
            if (m_busy[u] == 0) begin
                m_total[u] = p_total[u];
                m_ovf[u] = p_ovf[u];
                nd = 1'b1;
            end
        end else if (e[K_EQ]) begin
            m_total[u] = n;
            m_ovf[u] = 1'b0;
            m_dz[u] = 1'b0;
            nd = 1'b1;
        end else if (e[K_ADD] || e[K_SUB]) begin
            r = e[K_ADD] ? a + b : a - b;
            m_total[u] = r[W-1:0];
            m_ovf[u] = m_ovf[u] | !fits(u, r);
            nd = 1'b1;
        end else if (e[K_MUL] || (e[K_DIV] && b != 0)) begin
            r = e[K_MUL] ? a * b : a / b;
            p_total[u] = r[W-1:0];
            p_ovf[u] = m_ovf[u] | !fits(u, r);
            m_busy[u] = W + 1;
        end else if (e[K_DIV]) begin
            m_dz[u] = 1'b1;
            m_ovf[u] = 1'b1;
            nd = 1'b1;
        end
        m_done[u] = nd;
    endtask

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int u = 0; u < 2; u++) begin
                m_total[u] = '0; p_total[u] = '0; m_prev[u] = '0;
                m_ovf[u] = 1'b0; p_ovf[u] = 1'b0; m_dz[u] = 1'b0;
                m_done[u] = 1'b0; m_busy[u] = 0;
            end
        end else begin
            for (int u = 0; u < 2; u++) model_step(u);
        end
    end

    always @(negedge Clock) begin
        for (int u = 0; u < 2; u++) begin
            logic [W+3:0] o;
            o = outs_of(u);
            cmp($sformatf("u%0d.total", u),    longint'(o[W+3:4]), longint'(m_total[u]));
            cmp($sformatf("u%0d.overflow", u), longint'(o[3]),     longint'(m_ovf[u]));
            cmp($sformatf("u%0d.divzero", u),  longint'(o[2]),     longint'(m_dz[u]));
            cmp($sformatf("u%0d.busy", u),     longint'(o[1]),     longint'(m_busy[u] != 0));
            cmp($sformatf("u%0d.done", u),     longint'(o[0]),     longint'(m_done[u]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(int n);
        repeat (n) begin
            @(negedge Clock);
            #1;
        end
    endtask

    task automatic set_key(int u, int k, logic v);
        if (u == 0) begin
            case (k)
                K_CLR: if0.Clear = v;
                K_EQ:  if0.Equals = v;
                K_ADD: if0.Add = v;
                K_SUB: if0.Sub = v;
                K_MUL: if0.Mul = v;
                default: if0.Div = v;
            endcase
        end else begin
            case (k)
                K_CLR: if1.Clear = v;
                K_EQ:  if1.Equals = v;
                K_ADD: if1.Add = v;
                K_SUB: if1.Sub = v;
                K_MUL: if1.Mul = v;
                default: if1.Div = v;
            endcase
        end
    endtask

    task automatic set_num(int u, int n);
        if (u == 0) if0.Number = W'(n);
        else        if1.Number = W'(n);
    endtask

    task automatic press(int u, int k, int n);
        set_num(u, n);
        set_key(u, k, 1'b1);
        step(1);
        set_key(u, k, 1'b0);
    endtask

    task automatic watch(int u, int ncyc, output int nb, output int nd);
        logic [W+3:0] o;
        nb = 0;
        nd = 0;
        for (int i = 0; i < ncyc; i++) begin
            o = outs_of(u);
            if (o[1]) nb++;
            if (o[0]) nd++;
            step(1);
        end
    endtask

    function automatic longint tot_s(int u);
        logic [W+3:0] o;
        o = outs_of(u);
        return sval(u, o[W+3:4]);
    endfunction

    initial begin
        int nb, nd;
        logic [W+3:0] o;
        Resetn = 1'b1;
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 6; k++) set_key(u, k, 1'b0);
            set_num(u, 0);
        end
        #1 Resetn = 1'b0;
        step(2);
        o = outs_of(0);
        cmp("reset_outputs", longint'(o), 0);
        Resetn = 1'b1;
        step(2);

        // Equals loads Number, Done for one cycle
        press(0, K_EQ, 300);
        cmp("eq_total", tot_s(0), 300);
        cmp("eq_done", longint'(if0.Done), 1);
        cmp("eq_flags", longint'({if0.Overflow, if0.DivZero}), 0);
        step(1);
        cmp("eq_done_pulse", longint'(if0.Done), 0);

        // Add with signed overflow; a held key adds only once
        press(0, K_EQ, 1000);
        step(1);
        set_num(0, 100);
        set_key(0, K_ADD, 1'b1);
        step(1);
        cmp("add_total", tot_s(0), -948);
        cmp("add_ovf", longint'(if0.Overflow), 1);
        step(19);
        cmp("add_hold_total", tot_s(0), -948);
        set_key(0, K_ADD, 1'b0);
        step(1);

        // Signed multiply; Number changes during ITER must not matter
        press(0, K_EQ, -37);
        step(1);
        press(0, K_MUL, 25);
        set_num(0, 5);
        watch(0, 16, nb, nd);
        cmp("mul_busy_cycles", nb, 12);
        cmp("mul_done_count", nd, 1);
        cmp("mul_total", tot_s(0), -925);
        cmp("mul_ovf", longint'(if0.Overflow), 0);
        cmp("model_mul_total", sval(0, m_total[0]), -925);

        // Signed divide, then divide by zero
        press(0, K_EQ, -100);
        step(1);
        press(0, K_DIV, 7);
        watch(0, 16, nb, nd);
        cmp("div_busy_cycles", nb, 12);
        cmp("div_total", tot_s(0), -14);
        press(0, K_DIV, 0);
        watch(0, 4, nb, nd);
        cmp("dz_busy_cycles", nb, 0);
        cmp("dz_done_count", nd, 1);
        cmp("dz_total", tot_s(0), -14);
        cmp("dz_flags", longint'({if0.Overflow, if0.DivZero}), 3);

        // Most-negative / -1 overflows and keeps -2^(W-1)
        press(0, K_EQ, -1024);
        step(1);
        press(0, K_DIV, -1);
        watch(0, 16, nb, nd);
        cmp("minneg_div_total", tot_s(0), -1024);
        cmp("minneg_div_ovf", longint'(if0.Overflow), 1);

        // Equals beats Add in the same cycle and clears sticky flags
        set_num(0, 50);
        set_key(0, K_EQ, 1'b1);
        set_key(0, K_ADD, 1'b1);
        step(1);
        set_key(0, K_EQ, 1'b0);
        set_key(0, K_ADD, 1'b0);
        cmp("prio_total", tot_s(0), 50);
        cmp("prio_flags", longint'({if0.Overflow, if0.DivZero}), 0);
        step(1);

        // Clear on the 4th Busy cycle aborts the multiply
        press(0, K_EQ, 10);
        step(1);
        press(0, K_MUL, 20);
        step(3);
        cmp("abort_busy_before", longint'(if0.Busy), 1);
        press(0, K_CLR, 0);
        cmp("abort_total", tot_s(0), 0);
        cmp("abort_busy", longint'(if0.Busy), 0);
        cmp("abort_done", longint'(if0.Done), 0);
        watch(0, 15, nb, nd);
        cmp("abort_quiet", longint'(nb + nd), 0);

        // Unsigned instance: borrow, then multiply overflow
        press(1, K_EQ, 5);
        step(1);
        press(1, K_SUB, 9);
        cmp("u_sub_total", tot_s(1), 2044);
        cmp("u_sub_ovf", longint'(if1.Overflow), 1);
        press(1, K_EQ, 700);
        step(1);
        press(1, K_MUL, 3);
        watch(1, 16, nb, nd);
        cmp("u_mul_busy_cycles", nb, 12);
        cmp("u_mul_total", tot_s(1), 52);
        cmp("u_mul_ovf", longint'(if1.Overflow), 1);
        cmp("model_u_mul_total", sval(1, m_total[1]), 52);

        // Asynchronous reset in the middle of ITER
        press(0, K_EQ, 10);
        step(1);
        press(0, K_MUL, 20);
        step(2);
        #2 Resetn = 1'b0;
        #1;
        o = outs_of(0);
        cmp("midreset_outputs", longint'(o), 0);
        step(1);
        Resetn = 1'b1;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
